// File: rtl/uq_tdd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uq_tdd_pkg                                                 |
// | Description : Shared types and constants for the TDD pattern monitor:    |
// |               FSM state encoding, default counter width and the 10 ms    |
// |               frame length in 122.88 MHz cycles (same as the generator). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uq_tdd_pkg;

  // 21 bits covers one full 10 ms frame (1 228 800 cycles) without wrap.
  localparam int unsigned CNT_WIDTH_DEFAULT = 21;
  localparam int unsigned FRAME_CYCLES      = 1228800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_MEAS = 2'd2
  } tdd_state_e;

endpackage : uq_tdd_pkg
`default_nettype wire

// File: rtl/uq_tdd_edge_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uq_tdd_edge_det                                            |
// | Description : Two-stage sampler for one enable line. Stage d1 is the     |
// |               sampled value used for all counting; d2 is a one-cycle     |
// |               delay of d1 so that rise = d1 & ~d2.                       |
// | Ports       : clk      - clock                                           |
// |               rst_n_i  - asynchronous active-low reset                   |
// |               d_i      - raw line                                        |
// |               d1_o     - sampled line                                    |
// |               rise_o   - one-cycle rising-edge strobe aligned with d1    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uq_tdd_edge_det (
  input  logic clk,
  input  logic rst_n_i,
  input  logic d_i,
  output logic d1_o,
  output logic rise_o
);

  logic d1_q;
  logic d2_q;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= d_i;
      d2_q <= d1_q;
    end
  end

  assign d1_o   = d1_q;
  assign rise_o = d1_q & ~d2_q;

endmodule : uq_tdd_edge_det
`default_nettype wire

// File: rtl/uq_tdd_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uq_tdd_mon                                                 |
// | Description : TDD pattern monitor. Measures, per DL period, the period   |
// |               length, DL-on and UL-on cycles and the offset from the     |
// |               10 ms frame tick; declares lock after pLOCK_CNT matching   |
// |               periods and flags mismatch, timeout and DL/UL overlap.     |
// | Ports       : clk, i_rst_n (async, active-low), i_en, i_tick_10ms,       |
// |               i_tdd_dl, i_tdd_ul, i_clr -> o_period, o_dl_len, o_ul_len, |
// |               o_frame_ofs, o_meas_vld, o_lock, o_mismatch, o_timeout,    |
// |               o_conflict                                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uq_tdd_mon
  import uq_tdd_pkg::*;
#(
  parameter int unsigned pCNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int unsigned pLOCK_CNT  = 3,
  parameter int unsigned pTOL       = 2
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_tick_10ms,
  input  logic                  i_tdd_dl,
  input  logic                  i_tdd_ul,
  input  logic                  i_clr,
  output logic [pCNT_WIDTH-1:0] o_period,
  output logic [pCNT_WIDTH-1:0] o_dl_len,
  output logic [pCNT_WIDTH-1:0] o_ul_len,
  output logic [pCNT_WIDTH-1:0] o_frame_ofs,
  output logic                  o_meas_vld,
  output logic                  o_lock,
  output logic                  o_mismatch,
  output logic                  o_timeout,
  output logic                  o_conflict
);

  localparam int unsigned MC_W = (pLOCK_CNT < 1) ? 1 : $clog2(pLOCK_CNT + 1);

  localparam logic [pCNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [pCNT_WIDTH-1:0] CNT_ONE  = pCNT_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0] TOL_V    = pCNT_WIDTH'(pTOL);
  localparam logic [MC_W-1:0]       LOCK_TGT = MC_W'(pLOCK_CNT);

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
  logic dl_d1;
  logic dl_rise;
  logic ul_d1;

  uq_tdd_edge_det u_dl_edge (
    .clk     (clk),
    .rst_n_i (i_rst_n),
    .d_i     (i_tdd_dl),
    .d1_o    (dl_d1),
    .rise_o  (dl_rise)
  );

  // UL only contributes its sampled level; its edge is not needed.
  uq_tdd_edge_det u_ul_edge (
    .clk     (clk),
    .rst_n_i (i_rst_n),
    .d_i     (i_tdd_ul),
    .d1_o    (ul_d1),
    .rise_o  ()
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  tdd_state_e              state_q,     state_d;
  logic [pCNT_WIDTH-1:0]   per_cnt_q,   per_cnt_d;
  logic [pCNT_WIDTH-1:0]   dl_cnt_q,    dl_cnt_d;
  logic [pCNT_WIDTH-1:0]   ul_cnt_q,    ul_cnt_d;
  logic [pCNT_WIDTH-1:0]   ofs_cnt_q,   ofs_cnt_d;
  logic [pCNT_WIDTH-1:0]   period_q,    period_d;
  logic [pCNT_WIDTH-1:0]   dl_len_q,    dl_len_d;
  logic [pCNT_WIDTH-1:0]   ul_len_q,    ul_len_d;
  logic [pCNT_WIDTH-1:0]   frame_ofs_q, frame_ofs_d;
  logic                    meas_vld_q,  meas_vld_d;
  logic                    lock_q,      lock_d;
  logic                    mismatch_q,  mismatch_d;
  logic                    timeout_q,   timeout_d;
  logic                    conflict_q,  conflict_d;
  logic                    has_ref_q,   has_ref_d;
  logic [MC_W-1:0]         match_cnt_q, match_cnt_d;
  logic                    tick_d1_q;

  logic                    timeout_set;
  logic                    fields_match;
  logic [MC_W-1:0]         match_cnt_inc;
  logic [pCNT_WIDTH-1:0]   ofs_now;

  function automatic logic [pCNT_WIDTH-1:0] sat_inc(
    input logic [pCNT_WIDTH-1:0] v,
    input logic                  inc
  );
    return (inc && (v != CNT_MAX)) ? v + CNT_ONE : v;
  endfunction

  function automatic logic within_tol(
    input logic [pCNT_WIDTH-1:0] a,
    input logic [pCNT_WIDTH-1:0] b
  );
    logic [pCNT_WIDTH-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff <= TOL_V);
  endfunction

  // The just-finished period is compared against the fields still held on
  // the outputs, which are the previous measurement.
  assign fields_match  = within_tol(per_cnt_q, period_q) &&
                         within_tol(dl_cnt_q,  dl_len_q) &&
                         within_tol(ul_cnt_q,  ul_len_q);

  assign match_cnt_inc = (match_cnt_q == LOCK_TGT) ? match_cnt_q
                                                   : match_cnt_q + 1'b1;

  // Tick and rise in the same cycle give offset 0.
  assign ofs_now = tick_d1_q ? '0 : ofs_cnt_q;

  // The frame counter follows the tick regardless of the monitor state so
  // the offset is valid as soon as the first period completes.
  assign ofs_cnt_d = tick_d1_q ? CNT_ONE : sat_inc(ofs_cnt_q, 1'b1);

  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    dl_cnt_d      = dl_cnt_q;
    ul_cnt_d      = ul_cnt_q;
    period_d      = period_q;
    dl_len_d      = dl_len_q;
    ul_len_d      = ul_len_q;
    frame_ofs_d   = frame_ofs_q;
    meas_vld_d    = 1'b0;
    mismatch_d    = 1'b0;
    lock_d        = lock_q;
    has_ref_d     = has_ref_q;
    match_cnt_d   = match_cnt_q;
    timeout_set   = 1'b0;

    if (!i_en) begin
      // Any partial period is discarded; data outputs keep the last values.
      state_d     = ST_IDLE;
      per_cnt_d   = '0;
      dl_cnt_d    = '0;
      ul_cnt_d    = '0;
      lock_d      = 1'b0;
      has_ref_d   = 1'b0;
      match_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
        end

        ST_ACQ: begin
          if (dl_rise) begin
            // The rise cycle is the first cycle of the new period.
            per_cnt_d   = CNT_ONE;
            dl_cnt_d    = {{(pCNT_WIDTH-1){1'b0}}, dl_d1};
            ul_cnt_d    = {{(pCNT_WIDTH-1){1'b0}}, ul_d1};
            has_ref_d   = 1'b0;
            match_cnt_d = '0;
            state_d     = ST_MEAS;
          end
        end

        ST_MEAS: begin
          if (dl_rise) begin
            period_d    = per_cnt_q;
            dl_len_d    = dl_cnt_q;
            ul_len_d    = ul_cnt_q;
            frame_ofs_d = ofs_now;
            meas_vld_d  = 1'b1;
            per_cnt_d   = CNT_ONE;
            dl_cnt_d    = {{(pCNT_WIDTH-1){1'b0}}, dl_d1};
            ul_cnt_d    = {{(pCNT_WIDTH-1){1'b0}}, ul_d1};

            if (!has_ref_q) begin
              has_ref_d   = 1'b1;
              match_cnt_d = '0;
            end else if (fields_match) begin
              match_cnt_d = match_cnt_inc;
              lock_d      = lock_q | (match_cnt_inc == LOCK_TGT);
            end else begin
              match_cnt_d = '0;
              mismatch_d  = lock_q;
              lock_d      = 1'b0;
            end
          end else if (per_cnt_q >= (CNT_MAX - CNT_ONE)) begin
            // Period counter would reach saturation: DL pulses lost.
            timeout_set = 1'b1;
            lock_d      = 1'b0;
            has_ref_d   = 1'b0;
            match_cnt_d = '0;
            state_d     = ST_ACQ;
          end else begin
            per_cnt_d = per_cnt_q + CNT_ONE;
            dl_cnt_d  = sat_inc(dl_cnt_q, dl_d1);
            ul_cnt_d  = sat_inc(ul_cnt_q, ul_d1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Sticky flags: a new set wins over a simultaneous clear.
    timeout_d  = (timeout_q  & ~i_clr) | timeout_set;
    conflict_d = (conflict_q & ~i_clr) | (dl_d1 & ul_d1);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      per_cnt_q   <= '0;
      dl_cnt_q    <= '0;
      ul_cnt_q    <= '0;
      ofs_cnt_q   <= '0;
      period_q    <= '0;
      dl_len_q    <= '0;
      ul_len_q    <= '0;
      frame_ofs_q <= '0;
      meas_vld_q  <= 1'b0;
      lock_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
      conflict_q  <= 1'b0;
      has_ref_q   <= 1'b0;
      match_cnt_q <= '0;
      tick_d1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      dl_cnt_q    <= dl_cnt_d;
      ul_cnt_q    <= ul_cnt_d;
      ofs_cnt_q   <= ofs_cnt_d;
      period_q    <= period_d;
      dl_len_q    <= dl_len_d;
      ul_len_q    <= ul_len_d;
      frame_ofs_q <= frame_ofs_d;
      meas_vld_q  <= meas_vld_d;
      lock_q      <= lock_d;
      mismatch_q  <= mismatch_d;
      timeout_q   <= timeout_d;
      conflict_q  <= conflict_d;
      has_ref_q   <= has_ref_d;
      match_cnt_q <= match_cnt_d;
      tick_d1_q   <= i_tick_10ms;
    end
  end

  assign o_period    = period_q;
  assign o_dl_len    = dl_len_q;
  assign o_ul_len    = ul_len_q;
  assign o_frame_ofs = frame_ofs_q;
  assign o_meas_vld  = meas_vld_q;
  assign o_lock      = lock_q;
  assign o_mismatch  = mismatch_q;
  assign o_timeout   = timeout_q;
  assign o_conflict  = conflict_q;

endmodule : uq_tdd_mon
`default_nettype wire

// File: tb/tb_uq_tdd_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uq_tdd_mon                                              |
// | Description : Directed self-checking bench for uq_tdd_mon, built with    |
// |               an 8-bit counter width so the timeout is reachable.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uq_tdd_mon;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         tick  = 1'b0;
  logic         dl    = 1'b0;
  logic         ul    = 1'b0;
  logic         clr   = 1'b0;
  logic [W-1:0] period, dl_len, ul_len, frame_ofs;
  logic         meas_vld, lock, mismatch, timeout, conflict;

  int n_cmp = 0;
  int n_err = 0;
  int n_vld, n_mm, n_lock;
  logic         lock_at [0:31];
  logic         mm_at   [0:31];
  logic [W-1:0] per_at  [0:31];
  logic [W-1:0] dl_at   [0:31];
  logic [W-1:0] ul_at   [0:31];
  logic [W-1:0] ofs_at  [0:31];

  uq_tdd_mon #(.pCNT_WIDTH(W), .pLOCK_CNT(3), .pTOL(2)) dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_tick_10ms (tick),
    .i_tdd_dl    (dl),
    .i_tdd_ul    (ul),
    .i_clr       (clr),
    .o_period    (period),
    .o_dl_len    (dl_len),
    .o_ul_len    (ul_len),
    .o_frame_ofs (frame_ofs),
    .o_meas_vld  (meas_vld),
    .o_lock      (lock),
    .o_mismatch  (mismatch),
    .o_timeout   (timeout),
    .o_conflict  (conflict)
  );

  always #5 clk = ~clk;

  // One clock: inputs already set are sampled at the edge; outputs are
  // observed 1 ns later and strobes are logged.
  task automatic clk_step();
    @(posedge clk);
    #1;
    if (meas_vld) begin
      if (n_vld < 32) begin
        lock_at[n_vld] = lock;
        mm_at[n_vld]   = mismatch;
        per_at[n_vld]  = period;
        dl_at[n_vld]   = dl_len;
        ul_at[n_vld]   = ul_len;
        ofs_at[n_vld]  = frame_ofs;
      end
      n_vld++;
    end
    if (mismatch) n_mm++;
    if (lock) n_lock++;
  endtask

  task automatic clear_stats();
    n_vld = 0; n_mm = 0; n_lock = 0;
  endtask

  task automatic run_period(input int n, input int dlen, input int ulen, input int tick_pos);
    for (int i = 0; i < n; i++) begin
      dl   = (i < dlen);
      ul   = (i >= dlen) && (i < dlen + ulen);
      tick = (i == tick_pos);
      clk_step();
    end
    dl = 1'b0; ul = 1'b0; tick = 1'b0;
  endtask

  task automatic restart();
    dl = 1'b0; ul = 1'b0; en = 1'b0;
    clk_step(); clk_step();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_step(); clk_step();
    if ({period, dl_len, ul_len, frame_ofs} !== '0) begin
      n_err++; $display("FAIL reset_fields: got %h expected 0", {period, dl_len, ul_len, frame_ofs});
    end
    n_cmp++;
    if ({meas_vld, lock, mismatch, timeout, conflict} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 00000", {meas_vld, lock, mismatch, timeout, conflict});
    end
    n_cmp++;
    rst_n = 1'b1;
    clk_step();
  endtask

  task automatic test_lock();
    clear_stats();
    en = 1'b1;
    for (int p = 0; p < 5; p++) run_period(100, 30, 50, -1);
    if (n_vld !== 4) begin n_err++; $display("FAIL lock_nvld: got %0d expected 4", n_vld); end
    n_cmp++;
    if (per_at[3] !== 8'd100) begin n_err++; $display("FAIL lock_period: got %0d expected 100", per_at[3]); end
    n_cmp++;
    if (dl_at[3] !== 8'd30) begin n_err++; $display("FAIL lock_dl_len: got %0d expected 30", dl_at[3]); end
    n_cmp++;
    if (ul_at[3] !== 8'd50) begin n_err++; $display("FAIL lock_ul_len: got %0d expected 50", ul_at[3]); end
    n_cmp++;
    if (lock_at[3] !== 1'b1) begin n_err++; $display("FAIL lock_on_4th: got %b expected 1", lock_at[3]); end
    n_cmp++;
    if (lock_at[2] !== 1'b0) begin n_err++; $display("FAIL lock_on_3rd: got %b expected 0", lock_at[2]); end
    n_cmp++;
    // Lock appears one cycle into the 5th period and holds for the rest of it.
    if (n_lock !== 99) begin n_err++; $display("FAIL lock_cycles: got %0d expected 99", n_lock); end
    n_cmp++;
  endtask

  task automatic test_mismatch();
    clear_stats();
    for (int p = 0; p < 5; p++) run_period(110, 30, 50, -1);
    if (n_vld !== 5) begin n_err++; $display("FAIL mm_nvld: got %0d expected 5", n_vld); end
    n_cmp++;
    if (lock_at[0] !== 1'b1) begin n_err++; $display("FAIL mm_lock_held: got %b expected 1", lock_at[0]); end
    n_cmp++;
    if (mm_at[1] !== 1'b1 || lock_at[1] !== 1'b0) begin
      n_err++; $display("FAIL mm_pulse: got mm=%b lock=%b expected mm=1 lock=0", mm_at[1], lock_at[1]);
    end
    n_cmp++;
    if (n_mm !== 1) begin n_err++; $display("FAIL mm_count: got %0d expected 1", n_mm); end
    n_cmp++;
    if (lock_at[3] !== 1'b0) begin n_err++; $display("FAIL mm_early_relock: got %b expected 0", lock_at[3]); end
    n_cmp++;
    if (lock_at[4] !== 1'b1 || per_at[4] !== 8'd110) begin
      n_err++; $display("FAIL mm_relock: got lock=%b period=%0d expected lock=1 period=110", lock_at[4], per_at[4]);
    end
    n_cmp++;
  endtask

  task automatic test_jitter();
    restart();
    clear_stats();
    for (int p = 0; p < 7; p++) run_period((p % 2 == 0) ? 100 : 102, 30, 50, -1);
    if (lock_at[2] !== 1'b0 || lock_at[3] !== 1'b1) begin
      n_err++; $display("FAIL jit2_lock_point: got %b%b expected 01", lock_at[2], lock_at[3]);
    end
    n_cmp++;
    if (lock_at[5] !== 1'b1 || n_mm !== 0) begin
      n_err++; $display("FAIL jit2_held: got lock=%b mm=%0d expected lock=1 mm=0", lock_at[5], n_mm);
    end
    n_cmp++;
    restart();
    clear_stats();
    for (int p = 0; p < 7; p++) run_period((p % 2 == 0) ? 100 : 103, 30, 50, -1);
    if (n_vld !== 6 || n_lock !== 0) begin
      n_err++; $display("FAIL jit3_nolock: got vld=%0d lockcyc=%0d expected vld=6 lockcyc=0", n_vld, n_lock);
    end
    n_cmp++;
  endtask

  task automatic test_conflict();
    en = 1'b0;
    clk_step();
    if (conflict !== 1'b0) begin n_err++; $display("FAIL cf_initial: got %b expected 0", conflict); end
    n_cmp++;
    dl = 1'b1; ul = 1'b1;
    clk_step();
    if (conflict !== 1'b0) begin n_err++; $display("FAIL cf_latency: got %b expected 0", conflict); end
    n_cmp++;
    dl = 1'b0; ul = 1'b0; clr = 1'b1;
    clk_step();
    clr = 1'b0;
    if (conflict !== 1'b1) begin n_err++; $display("FAIL cf_set_wins: got %b expected 1", conflict); end
    n_cmp++;
    clk_step(); clk_step(); clk_step();
    if (conflict !== 1'b1) begin n_err++; $display("FAIL cf_sticky: got %b expected 1", conflict); end
    n_cmp++;
    clr = 1'b1;
    clk_step();
    clr = 1'b0;
    if (conflict !== 1'b0) begin n_err++; $display("FAIL cf_clear: got %b expected 0", conflict); end
    n_cmp++;
  endtask

  task automatic test_timeout();
    restart();
    clear_stats();
    for (int p = 0; p < 4; p++) run_period(100, 30, 50, -1);
    // Last DL pulse: rise sampled at step 0, then the line stays low.
    for (int s = 0; s < 262; s++) begin
      dl = (s < 30);
      clk_step();
      if (s == 254) begin
        if (timeout !== 1'b0 || lock !== 1'b1) begin
          n_err++; $display("FAIL to_before: got to=%b lock=%b expected to=0 lock=1", timeout, lock);
        end
        n_cmp++;
      end
      if (s == 255) begin
        if (timeout !== 1'b1 || lock !== 1'b0) begin
          n_err++; $display("FAIL to_set: got to=%b lock=%b expected to=1 lock=0", timeout, lock);
        end
        n_cmp++;
      end
    end
    clr = 1'b1;
    clk_step();
    clr = 1'b0;
    if (timeout !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b expected 0", timeout); end
    n_cmp++;
    clear_stats();
    run_period(100, 30, 50, -1);
    if (n_vld !== 0) begin n_err++; $display("FAIL to_acq_nostrobe: got %0d expected 0", n_vld); end
    n_cmp++;
  endtask

  task automatic test_frame_ofs();
    restart();
    clear_stats();
    run_period(100, 30, 50, 93);
    run_period(100, 30, 50, -1);
    run_period(100, 30, 50, 0);
    run_period(100, 30, 50, -1);
    if (ofs_at[0] !== 8'd7) begin n_err++; $display("FAIL ofs_7: got %0d expected 7", ofs_at[0]); end
    n_cmp++;
    if (ofs_at[1] !== 8'd0) begin n_err++; $display("FAIL ofs_coincide: got %0d expected 0", ofs_at[1]); end
    n_cmp++;
    if (ofs_at[2] !== 8'd100 || n_vld !== 3) begin
      n_err++; $display("FAIL ofs_100: got ofs=%0d vld=%0d expected ofs=100 vld=3", ofs_at[2], n_vld);
    end
    n_cmp++;
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < 50; i++) begin
      dl = (i < 30); ul = (i >= 30) && (i < 80);
      clk_step();
    end
    clear_stats();
    en = 1'b0;
    for (int i = 50; i < 300; i++) begin
      dl = ((i % 100) < 30); ul = ((i % 100) >= 30) && ((i % 100) < 80);
      clk_step();
    end
    dl = 1'b0; ul = 1'b0;
    if (n_vld !== 0) begin n_err++; $display("FAIL en_drop_nostrobe: got %0d expected 0", n_vld); end
    n_cmp++;
    if (period !== 8'd100 || lock !== 1'b0) begin
      n_err++; $display("FAIL en_drop_hold: got period=%0d lock=%b expected period=100 lock=0", period, lock);
    end
    n_cmp++;
  endtask

  task automatic test_async_reset();
    restart();
    for (int p = 0; p < 3; p++) run_period(100, 30, 50, -1);
    if (period !== 8'd100) begin n_err++; $display("FAIL ar_pre_period: got %0d expected 100", period); end
    n_cmp++;
    dl = 1'b1; ul = 1'b1;
    clk_step();
    dl = 1'b0; ul = 1'b0;
    clk_step();
    if (conflict !== 1'b1) begin n_err++; $display("FAIL ar_pre_conflict: got %b expected 1", conflict); end
    n_cmp++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({period, dl_len, ul_len, frame_ofs} !== '0 ||
        {meas_vld, lock, mismatch, timeout, conflict} !== 5'b0) begin
      n_err++; $display("FAIL ar_outputs: got %h/%b expected 0/00000",
                        {period, dl_len, ul_len, frame_ofs}, {meas_vld, lock, mismatch, timeout, conflict});
    end
    n_cmp++;
    clk_step();
    rst_n = 1'b1;
    clk_step();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_jitter();
    test_conflict();
    test_timeout();
    test_frame_ofs();
    test_en_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uq_tdd_mon
`default_nettype wire

// File: doc/uq_tdd_mon.md
# uq_tdd_mon

TDD pattern monitor: the receive-side counterpart of the TDD pattern generator. It samples the DL/UL enable lines that the generator drives toward the radio path and measures, per TDD period, the DL-on cycles, UL-on cycles, period length and offset from the 10 ms frame tick. It declares lock once the pattern is stable and flags mismatches, timeouts and DL/UL overlap. It sits on the 122.88 MHz domain beside the generator; status is read via registers and the bench.

## Interface
- pCNT_WIDTH, 21: width of all cycle counters (covers 1 228 800 cycles per 10 ms).
- pLOCK_CNT, 3: consecutive matching periods required for lock.
- pTOL, 2: allowed absolute difference (cycles) per measured field for a match.

- clk  in  1  122.88 MHz clock, single domain.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  monitor enable.
- i_tick_10ms  in  1  one-cycle frame strobe.
- i_tdd_dl  in  1  DL enable line under test.
- i_tdd_ul  in  1  UL enable line under test.
- i_clr  in  1  clears sticky flags.
- o_period  out  pCNT_WIDTH  cycles between consecutive DL rising edges.
- o_dl_len  out  pCNT_WIDTH  cycles i_tdd_dl sampled high in that period.
- o_ul_len  out  pCNT_WIDTH  cycles i_tdd_ul sampled high in that period.
- o_frame_ofs  out  pCNT_WIDTH  cycles from last i_tick_10ms to the DL rising edge.
- o_meas_vld  out  1  one-cycle strobe: the four fields above updated.
- o_lock  out  1  pattern stable.
- o_mismatch  out  1  one-cycle strobe: lock lost on a mismatched period.
- o_timeout  out  1  sticky: no DL rising edge within 2^pCNT_WIDTH-1 cycles.
- o_conflict  out  1  sticky: DL and UL sampled high in the same cycle.

## Operation
- Inputs registered (d1), then delayed (d2); rise = d1 & ~d2. All counting uses d1.
- States: IDLE, ACQ, MEAS.
  - IDLE: i_en=0. Counters cleared, o_lock=0, data outputs hold.
  - ACQ: entered on i_en=1. Waits for rise; on rise clears period/DL/UL counters, goes to MEAS, no o_meas_vld.
  - MEAS: period counter +1 per cycle; DL/UL counters +1 per cycle d1 is high (non-contiguous highs summed). On rise: register fields, pulse o_meas_vld, restart counters at the rise cycle.
- Period definition: rises every N cycles give o_period=N; the rise cycle counts toward the new period.
- Counters saturate at 2^pCNT_WIDTH-1. Period counter reaching saturation: set o_timeout, clear lock, go to ACQ.
- Frame offset counter is cleared on i_tick_10ms and saturates. If a tick and a rise coincide, o_frame_ofs=0.
- Match rule: all of period, dl_len and ul_len within pTOL of the previous measurement.
  - First measurement after ACQ is reference only; match_cnt=0.
  - On match: match_cnt+1 (saturating). o_lock=1 when match_cnt reaches pLOCK_CNT.
  - On miss: match_cnt=0, new reference. If o_lock was 1: pulse o_mismatch, o_lock=0.
- o_conflict sets when d1 of DL and UL are both 1. i_clr clears o_conflict and o_timeout; set wins over simultaneous clear.
- i_en deasserted mid-period: IDLE next cycle, partial period discarded, no strobe.

## Timing
- Reset values: all outputs 0, state IDLE, d1/d2 0.
- Latency: i_tdd_dl first sampled high at edge k → o_meas_vld and new fields visible after edge k+1; o_lock/o_mismatch change in the same cycle as that o_meas_vld.
- o_conflict sets after the edge following the overlapping sample (d1 register + flag register).
- o_meas_vld and o_mismatch are never high more than one cycle consecutively.

## Structure
- Package uq_tdd_pkg: state enum (IDLE/ACQ/MEAS), default pCNT_WIDTH, and the 1 228 800-cycle frame constant shared with the generator.
- Sub-module uq_tdd_edge_det: input register, delay, rise output. Instantiated for DL and UL.

## Test plan
- DL high 30 of every 100 cycles, UL high 50 of every 100, i_en=1 → 4th o_meas_vld shows period=100, dl=30, ul=50, with o_lock=1 on that strobe; no lock before it.
- Locked, then one period of 110 → o_mismatch pulse, o_lock=0; relock after 3 further matching periods of 110.
- Period jitter alternating 100/102 with pTOL=2 → lock held; jitter 100/103 → lock never asserts.
- DL and UL both high for 1 cycle; i_clr in the same cycle, then i_clr alone → o_conflict=1 until the lone clear, then 0.
- Stop DL pulses (pCNT_WIDTH=8 build) → o_timeout=1 after 255 cycles, o_lock=0, state ACQ; next rise gives no strobe.
- Tick 7 cycles before a DL rise → o_frame_ofs=7. Drop i_en mid-period → no strobe; async reset asserted mid-MEAS → all outputs 0 immediately.
